// File: rtl/axi_line_pkg.sv
// Shared constants and the responder state encoding for the 512-bit line-side
// AXI4 memory responder.
package axi_line_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam int         LINE_BYTES  = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } rsp_state_t;

endpackage

// File: rtl/line_mem_responder_if.sv
// AXI4 channel bundle between the cache line-side master and the line memory
// responder.
interface line_mem_responder_if #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
) ();

  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [ID_W-1:0]     arid;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [ID_W-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [ID_W-1:0]     awid;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arid, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arlen, arsize, arburst, arid, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/line_ram.sv
// Single-port line RAM: one full cache line per word, per-byte write enables,
// registered read that holds its value until the next read enable.
module line_ram #(
  parameter int DATA_W     = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++) begin
      if (we[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (en) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_mem_responder.sv
// AXI4 slave memory model for the cache's 512-bit line port: one transaction at
// a time, INCR bursts of whole lines, byte strobes, ID echo, SLVERR on range.
module line_mem_responder
  import axi_line_pkg::*;
#(
  parameter int ADDR_W     = 31,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input logic                 clk,
  input logic                 rstn,
  line_mem_responder_if.slave s_axi
);

  rsp_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                last_rd_q, last_rd_d;
  logic                err_q, err_d;
  logic                rdy_en_q, rdy_en_d;

  logic                in_range, is_last, both_req, pick_rd, pick_wr;
  logic                ram_en;
  logic [DATA_W/8-1:0] ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  logic                ar_rdy, aw_rdy, w_rdy, r_vld, r_last, b_vld;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp, b_resp;
  logic [ID_W-1:0]     r_id, b_id;

  logic                unused_ok;
  assign unused_ok = ^{s_axi.arsize, s_axi.arburst, s_axi.awsize, s_axi.awburst};

  assign in_range = (addr_q[ADDR_W-1:DEPTH_LOG2+6] == '0);
  assign is_last  = (cnt_q == len_q);

  // Alternating priority on a simultaneous request; the loser's ready is held low
  // in that cycle so it never sees a handshake it was not granted.
  assign both_req = s_axi.arvalid && s_axi.awvalid;
  assign pick_wr  = s_axi.awvalid && (!s_axi.arvalid || last_rd_q);
  assign pick_rd  = s_axi.arvalid && !pick_wr;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_rd_d = last_rd_q;
    err_d     = err_q;
    rdy_en_d  = 1'b1;
    ram_en    = 1'b0;
    ram_we    = '0;
    ar_rdy    = 1'b0;
    aw_rdy    = 1'b0;
    w_rdy     = 1'b0;
    r_vld     = 1'b0;
    r_data    = '0;
    r_resp    = RESP_OKAY;
    r_last    = 1'b0;
    r_id      = '0;
    b_vld     = 1'b0;
    b_resp    = RESP_OKAY;
    b_id      = '0;
    unique case (state_q)
      IDLE: begin
        ar_rdy = rdy_en_q && !(both_req && last_rd_q);
        aw_rdy = rdy_en_q && !(both_req && !last_rd_q);
        if (rdy_en_q && pick_rd) begin
          addr_d    = s_axi.araddr;
          len_d     = s_axi.arlen;
          id_d      = s_axi.arid;
          cnt_d     = '0;
          last_rd_d = 1'b1;
          state_d   = RD_REQ;
        end else if (rdy_en_q && pick_wr) begin
          addr_d    = s_axi.awaddr;
          len_d     = s_axi.awlen;
          id_d      = s_axi.awid;
          cnt_d     = '0;
          err_d     = 1'b0;
          last_rd_d = 1'b0;
          state_d   = WR_DATA;
        end
      end
      RD_REQ: begin
        ram_en  = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        // RAM output only changes on ram_en, so the beat stays stable under backpressure.
        r_vld  = 1'b1;
        r_data = in_range ? ram_rdata : '0;
        r_resp = in_range ? RESP_OKAY : RESP_SLVERR;
        r_last = is_last;
        r_id   = id_q;
        if (s_axi.rready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(LINE_BYTES);
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        w_rdy = 1'b1;
        if (s_axi.wvalid) begin
          if (in_range) ram_we = s_axi.wstrb;
          else          err_d  = 1'b1;
          if (s_axi.wlast != is_last) err_d = 1'b1;
          if (is_last) begin
            state_d = WR_RESP;
          end else begin
            addr_d = addr_q + ADDR_W'(LINE_BYTES);
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        b_vld  = 1'b1;
        b_id   = id_q;
        b_resp = err_q ? RESP_SLVERR : RESP_OKAY;
        if (s_axi.bready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      id_q      <= '0;
      last_rd_q <= 1'b0;
      err_q     <= 1'b0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_rd_q <= last_rd_d;
      err_q     <= err_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  line_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q[DEPTH_LOG2+5:6]),
    .wdata (s_axi.wdata),
    .rdata (ram_rdata)
  );

  assign s_axi.arready = ar_rdy;
  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rdata   = r_data;
  assign s_axi.rresp   = r_resp;
  assign s_axi.rlast   = r_last;
  assign s_axi.rid     = r_id;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bresp   = b_resp;
  assign s_axi.bid     = b_id;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: round trip, strobes, backpressured burst,
// range errors, AR/AW arbitration and reset in the middle of a burst.
module tb_line_mem_responder;
  import axi_line_pkg::*;

  localparam int ADDR_W     = 31;
  localparam int DATA_W     = 512;
  localparam int ID_W       = 4;
  localparam int DEPTH_LOG2 = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  line_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  line_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_axi (axi)
  );

  logic [DATA_W-1:0] pat_a, pat_b, ones, merged;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_xfer(input logic [ADDR_W-1:0] a, input logic [7:0] len, input logic [ID_W-1:0] id);
    logic done = 1'b0;
    axi.araddr = a; axi.arlen = len; axi.arid = id;
    axi.arsize = 3'd6; axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = axi.arready;
      tick();
    end
    axi.arvalid = 1'b0;
    chk("ar_handshake", DATA_W'(done), DATA_W'(1));
  endtask

  task automatic aw_xfer(input logic [ADDR_W-1:0] a, input logic [7:0] len, input logic [ID_W-1:0] id);
    logic done = 1'b0;
    axi.awaddr = a; axi.awlen = len; axi.awid = id;
    axi.awsize = 3'd6; axi.awburst = BURST_INCR; axi.awvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = axi.awready;
      tick();
    end
    axi.awvalid = 1'b0;
    chk("aw_handshake", DATA_W'(done), DATA_W'(1));
  endtask

  task automatic w_beat(input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s, input logic last);
    logic done = 1'b0;
    axi.wdata = d; axi.wstrb = s; axi.wlast = last; axi.wvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      done = axi.wready;
      tick();
    end
    axi.wvalid = 1'b0;
    chk("w_handshake", DATA_W'(done), DATA_W'(1));
  endtask

  task automatic b_take(input string tag, input logic [ID_W-1:0] id, input logic [1:0] resp);
    logic done = 1'b0;
    axi.bready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (axi.bvalid) begin
        done = 1'b1;
        chk({tag, "_bid"}, DATA_W'(axi.bid), DATA_W'(id));
        chk({tag, "_bresp"}, DATA_W'(axi.bresp), DATA_W'(resp));
        chk({tag, "_no_rvalid"}, DATA_W'(axi.rvalid), DATA_W'(0));
      end
      tick();
    end
    axi.bready = 1'b0;
    chk({tag, "_b_seen"}, DATA_W'(done), DATA_W'(1));
  endtask

  task automatic r_take(input string tag, input logic [DATA_W-1:0] d, input logic [1:0] resp,
                        input logic last, input logic [ID_W-1:0] id);
    logic done = 1'b0;
    axi.rready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (axi.rvalid) begin
        done = 1'b1;
        chk({tag, "_rdata"}, axi.rdata, d);
        chk({tag, "_rresp"}, DATA_W'(axi.rresp), DATA_W'(resp));
        chk({tag, "_rlast"}, DATA_W'(axi.rlast), DATA_W'(last));
        chk({tag, "_rid"}, DATA_W'(axi.rid), DATA_W'(id));
      end
      tick();
    end
    axi.rready = 1'b0;
    chk({tag, "_r_seen"}, DATA_W'(done), DATA_W'(1));
  endtask

  task automatic write_line(input string tag, input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                            input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s,
                            input logic [1:0] resp);
    aw_xfer(a, 8'd0, id);
    w_beat(d, s, 1'b1);
    b_take(tag, id, resp);
  endtask

  initial begin
    pat_a  = {8{64'h0123_4567_89AB_CDEF}};
    pat_b  = {16{32'h5A5A_C3C3}};
    ones   = '1;
    merged = {{60{8'hFF}}, 32'h0000_0000};
    axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arid = '0; axi.arvalid = 1'b0;
    axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awid = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.rready = 1'b0; axi.bready = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_arready", DATA_W'(axi.arready), DATA_W'(0));
    chk("rst_awready", DATA_W'(axi.awready), DATA_W'(0));
    chk("rst_wready", DATA_W'(axi.wready), DATA_W'(0));
    chk("rst_rvalid", DATA_W'(axi.rvalid), DATA_W'(0));
    chk("rst_bvalid", DATA_W'(axi.bvalid), DATA_W'(0));
    chk("rst_rdata", axi.rdata, '0);
    chk("rst_bid_bresp", DATA_W'({axi.bid, axi.bresp}), DATA_W'(0));
    rstn = 1'b1;
    tick();
    chk("idle_arready", DATA_W'(axi.arready), DATA_W'(1));
    chk("idle_awready", DATA_W'(axi.awready), DATA_W'(1));

    // Single write/read round trip with first-beat latency
    write_line("rt_wr", 31'h40, 4'd3, pat_a, '1, RESP_OKAY);
    ar_xfer(31'h40, 8'd0, 4'd5);
    #1;
    chk("rt_lat_cycle1", DATA_W'(axi.rvalid), DATA_W'(0));
    tick();
    chk("rt_lat_cycle2", DATA_W'(axi.rvalid), DATA_W'(1));
    r_take("rt_rd", pat_a, RESP_OKAY, 1'b1, 4'd5);

    // Byte strobe merge
    write_line("sb_full", 31'h80, 4'd1, ones, '1, RESP_OKAY);
    write_line("sb_part", 31'h80, 4'd2, '0, 64'h0000_0000_0000_000F, RESP_OKAY);
    ar_xfer(31'h80, 8'd0, 4'd6);
    r_take("sb_rd", merged, RESP_OKAY, 1'b1, 4'd6);

    // Burst read with backpressure on beat 1
    for (int k = 0; k < 4; k++) write_line("pre", ADDR_W'(k * 64), 4'd0, DATA_W'(k), '1, RESP_OKAY);
    ar_xfer(31'h0, 8'd3, 4'd7);
    r_take("bp_b0", DATA_W'(0), RESP_OKAY, 1'b0, 4'd7);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("bp_stall_rvalid", DATA_W'(axi.rvalid), DATA_W'(1));
      chk("bp_stall_rdata", axi.rdata, DATA_W'(1));
      chk("bp_stall_rlast", DATA_W'(axi.rlast), DATA_W'(0));
      tick();
    end
    r_take("bp_b1", DATA_W'(1), RESP_OKAY, 1'b0, 4'd7);
    r_take("bp_b2", DATA_W'(2), RESP_OKAY, 1'b0, 4'd7);
    r_take("bp_b3", DATA_W'(3), RESP_OKAY, 1'b1, 4'd7);
    #1;
    chk("bp_done_rvalid", DATA_W'(axi.rvalid), DATA_W'(0));

    // Out-of-range read and write; line 0 shares the low index bits and must survive
    ar_xfer(31'h1_0000, 8'd0, 4'd8);
    r_take("oor_rd", '0, RESP_SLVERR, 1'b1, 4'd8);
    write_line("oor_wr", 31'h1_0000, 4'd4, ones, '1, RESP_SLVERR);
    ar_xfer(31'h0, 8'd0, 4'd9);
    r_take("oor_keep", DATA_W'(0), RESP_OKAY, 1'b1, 4'd9);

    // Simultaneous AR/AW after a read: write goes first
    axi.araddr = 31'h0; axi.arlen = 8'd0; axi.arid = 4'd10; axi.arvalid = 1'b1;
    axi.awaddr = 31'h40; axi.awlen = 8'd0; axi.awid = 4'd11; axi.awvalid = 1'b1;
    #1;
    chk("arb_awready", DATA_W'(axi.awready), DATA_W'(1));
    chk("arb_arready", DATA_W'(axi.arready), DATA_W'(0));
    tick();
    axi.awvalid = 1'b0;
    chk("arb_ar_held", DATA_W'(axi.arready), DATA_W'(0));
    w_beat(pat_b, '1, 1'b1);
    b_take("arb_wr", 4'd11, RESP_OKAY);
    ar_xfer(31'h0, 8'd0, 4'd10);
    r_take("arb_rd", DATA_W'(0), RESP_OKAY, 1'b1, 4'd10);

    // Reset during beat 2 of a 4-beat read
    ar_xfer(31'h0, 8'd3, 4'd2);
    r_take("mr_b0", DATA_W'(0), RESP_OKAY, 1'b0, 4'd2);
    r_take("mr_b1", pat_b, RESP_OKAY, 1'b0, 4'd2);
    tick();
    chk("mr_beat2_up", DATA_W'(axi.rvalid), DATA_W'(1));
    rstn = 1'b0;
    tick();
    chk("mr_rvalid", DATA_W'(axi.rvalid), DATA_W'(0));
    chk("mr_arready", DATA_W'(axi.arready), DATA_W'(0));
    rstn = 1'b1;
    tick();
    chk("mr_ready_back", DATA_W'(axi.arready), DATA_W'(1));
    ar_xfer(31'h80, 8'd0, 4'd12);
    r_take("mr_after", DATA_W'(2), RESP_OKAY, 1'b1, 4'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
